// File: rtl/mem_bist_pkg.sv
// Shared types and constants for the memory BIST initiator.
package mem_bist_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrGap,
        StRdReq,
        StRdGap,
        StDone
    } state_e;

    localparam logic        PAT_ADDR = 1'b0;
    localparam logic        PAT_CHK  = 1'b1;
    localparam logic [15:0] CHK_EVEN = 16'h5555;
    localparam logic [15:0] CHK_ODD  = 16'hAAAA;

endpackage

// File: rtl/mem_bist_pattern.sv
// Combinational data pattern generator: address pattern or checkerboard by address parity.
module mem_bist_pattern
    import mem_bist_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  pat_sel_i,
    output logic [WIDTH-1:0]      data_o
);

    always_comb begin
        data_o = WIDTH'(addr_i);
        if (pat_sel_i == PAT_CHK) begin
            data_o = addr_i[0] ? WIDTH'(CHK_ODD) : WIDTH'(CHK_EVEN);
        end
    end

endmodule

// File: rtl/mem_bist_master.sv
// Write/read-back/compare BIST initiator for a valid/ready single-port memory.
// Optional first-mismatch logging enabled by defining MEM_BIST_ERR_LOG_EN.
module mem_bist_master
    import mem_bist_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned TIMEOUT    = 15,
    parameter int unsigned ERRW       = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] start_addr_i,
    input  logic [ADDR_WIDTH-1:0] last_addr_i,
    input  logic                  pat_sel_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [WIDTH-1:0]      wdata_o,
    output logic                  wr_rd_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    input  logic [WIDTH-1:0]      rdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  timeout_o,
    output logic [ERRW-1:0]       err_cnt_o
`ifdef MEM_BIST_ERR_LOG_EN
    ,
    output logic [ADDR_WIDTH-1:0] err_addr_o,
    output logic [WIDTH-1:0]      err_exp_o,
    output logic [WIDTH-1:0]      err_got_o
`endif
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] start_q, last_q, addr_q;
    logic                  pat_q;
    logic [WIDTH-1:0]      wdata_q;
    logic                  wr_rd_q, valid_q, busy_q, done_q, pass_q, timeout_q;
    logic [ERRW-1:0]       err_cnt_q;
    logic [CntW-1:0]       cnt_q;
`ifdef MEM_BIST_ERR_LOG_EN
    logic [ADDR_WIDTH-1:0] err_addr_q;
    logic [WIDTH-1:0]      err_exp_q, err_got_q;
`endif

    logic                  last_hit;
    logic [ADDR_WIDTH-1:0] addr_nxt, pat_addr;
    logic                  pat_sel;
    logic [WIDTH-1:0]      pat_data;
    logic                  mismatch;
    logic [ERRW-1:0]       err_inc;

    // One pattern instance: next write word in IDLE/WR_GAP, expected word in RD_REQ.
    always_comb begin
        last_hit = (addr_q == last_q);
        addr_nxt = last_hit ? start_q : addr_q + 1'b1;
        pat_sel  = pat_q;
        pat_addr = addr_nxt;
        if (state_q == StIdle) begin
            pat_sel  = pat_sel_i;
            pat_addr = start_addr_i;
        end else if (state_q == StRdReq) begin
            pat_addr = addr_q;
        end
        mismatch = (rdata_i != pat_data);
        err_inc  = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 1'b1;
    end

    mem_bist_pattern #(
        .WIDTH     (WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_pattern (
        .addr_i   (pat_addr),
        .pat_sel_i(pat_sel),
        .data_o   (pat_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            start_q   <= '0;
            last_q    <= '0;
            addr_q    <= '0;
            pat_q     <= 1'b0;
            wdata_q   <= '0;
            wr_rd_q   <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_cnt_q <= '0;
            cnt_q     <= '0;
`ifdef MEM_BIST_ERR_LOG_EN
            err_addr_q <= '0;
            err_exp_q  <= '0;
            err_got_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        start_q   <= start_addr_i;
                        last_q    <= last_addr_i;
                        pat_q     <= pat_sel_i;
                        addr_q    <= start_addr_i;
                        wdata_q   <= pat_data;
                        wr_rd_q   <= 1'b1;
                        valid_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        pass_q    <= 1'b0;
                        timeout_q <= 1'b0;
                        err_cnt_q <= '0;
                        cnt_q     <= '0;
`ifdef MEM_BIST_ERR_LOG_EN
                        err_addr_q <= '0;
                        err_exp_q  <= '0;
                        err_got_q  <= '0;
`endif
                        state_q   <= StWrReq;
                    end
                end
                StWrReq, StRdReq: begin
                    if (ready_i) begin
                        valid_q <= 1'b0;
                        if (state_q == StRdReq && mismatch) begin
                            err_cnt_q <= err_inc;
`ifdef MEM_BIST_ERR_LOG_EN
                            if (err_cnt_q == '0) begin
                                err_addr_q <= addr_q;
                                err_exp_q  <= pat_data;
                                err_got_q  <= rdata_i;
                            end
`endif
                        end
                        state_q <= (state_q == StWrReq) ? StWrGap : StRdGap;
                    end else if (cnt_q == CntMax) begin
                        valid_q   <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                        pass_q    <= 1'b0;
                        state_q   <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWrGap: begin
                    cnt_q   <= '0;
                    valid_q <= 1'b1;
                    addr_q  <= addr_nxt;
                    if (last_hit) begin
                        wr_rd_q <= 1'b0;
                        state_q <= StRdReq;
                    end else begin
                        wdata_q <= pat_data;
                        state_q <= StWrReq;
                    end
                end
                StRdGap: begin
                    if (last_hit) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_cnt_q == '0);
                        state_q <= StDone;
                    end else begin
                        cnt_q   <= '0;
                        valid_q <= 1'b1;
                        addr_q  <= addr_nxt;
                        state_q <= StRdReq;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign addr_o    = addr_q;
    assign wdata_o   = wdata_q;
    assign wr_rd_o   = wr_rd_q;
    assign valid_o   = valid_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign pass_o    = pass_q;
    assign timeout_o = timeout_q;
    assign err_cnt_o = err_cnt_q;
`ifdef MEM_BIST_ERR_LOG_EN
    assign err_addr_o = err_addr_q;
    assign err_exp_o  = err_exp_q;
    assign err_got_o  = err_got_q;
`endif

endmodule
